// File: rtl/flash_bus_arb.sv
// Shares one parallel NOR flash pin bundle among the erase (0), write (1) and read (2) engines.
// Round-robin grant, one-cycle launch pulse, registered pad mux, guard gap and watchdog abort.
//
// state | meaning
// IDLE  | pads parked, waiting for any request
// START | one-cycle eng_en pulse to the winner
// BUSY  | pads follow the owner, watchdog running
// GAP   | pads parked, guard time and wait for done to drop
// FAULT | owner held in reset, rst_f low
module flash_bus_arb #(
  parameter int unsigned WDOG_CYC = 5_000_000,
  parameter int unsigned GAP_CYC  = 8,
  parameter int unsigned RST_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  output logic [2:0]  eng_en,
  input  logic [2:0]  eng_done,
  output logic [2:0]  eng_rst_n,
  input  logic [74:0] eng_a,
  input  logic [47:0] eng_dq,
  input  logic [17:0] eng_ctl,
  output logic [24:0] A,
  output logic [15:0] dq_o,
  output logic        dqe,
  output logic        oe,
  output logic        ce,
  output logic        we,
  output logic        adv,
  output logic        rst_f,
  output logic        wp,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [2:0]  err
);

  typedef enum logic [2:0] {IDLE, START, BUSY, GAP, FAULT} state_t;

  // control bits are {rst_f, adv, we, ce, oe, dqe}
  localparam logic [5:0] CTL_PARK  = 6'b111110;
  localparam logic [5:0] CTL_FAULT = 6'b011110;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  err_q, err_d;
  logic [24:0] a_q, a_d;
  logic [15:0] dq_q, dq_d;
  logic [5:0]  ctl_q, ctl_d;

  logic [1:0]  win;
  logic [2:0]  win_oh, own_oh;
  logic [24:0] sel_a;
  logic [15:0] sel_dq;
  logic [5:0]  sel_ctl;
  logic        done_w;

  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_oh = 3'b001;
    case (win)
      2'd1:    win_oh = 3'b010;
      2'd2:    win_oh = 3'b100;
      default: win_oh = 3'b001;
    endcase
  end

  always_comb begin
    own_oh  = 3'b001;
    sel_a   = eng_a[24:0];
    sel_dq  = eng_dq[15:0];
    sel_ctl = eng_ctl[5:0];
    case (owner_q)
      2'd1: begin
        own_oh  = 3'b010;
        sel_a   = eng_a[49:25];
        sel_dq  = eng_dq[31:16];
        sel_ctl = eng_ctl[11:6];
      end
      2'd2: begin
        own_oh  = 3'b100;
        sel_a   = eng_a[74:50];
        sel_dq  = eng_dq[47:32];
        sel_ctl = eng_ctl[17:12];
      end
      default: ;
    endcase
  end

  assign done_w = |(eng_done & own_oh);

  // The watchdog is a down-counter loaded on launch and also decremented in
  // START, so terminal count in BUSY lands rst_f exactly WDOG_CYC after START.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = START;
          owner_d = win;
          last_d  = win;
          err_d   = err_q & ~win_oh;
          cnt_d   = WDOG_CYC - 32'd1;
        end
      end
      START: begin
        state_d = BUSY;
        cnt_d   = cnt_q - 32'd1;
      end
      BUSY: begin
        if (done_w) begin
          state_d = GAP;
          cnt_d   = GAP_CYC - 32'd1;
        end else if (cnt_q == 32'd0) begin
          state_d = FAULT;
          cnt_d   = RST_CYC - 32'd1;
          err_d   = err_q | own_oh;
        end else begin
          cnt_d   = cnt_q - 32'd1;
        end
      end
      FAULT: begin
        if (cnt_q == 32'd0) begin
          state_d = GAP;
          cnt_d   = GAP_CYC - 32'd1;
        end else begin
          cnt_d   = cnt_q - 32'd1;
        end
      end
      GAP: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (!done_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pads are loaded from the next state so that the done cycle never leaks
  // through and rst_f drops together with the engine reset.
  always_comb begin
    a_d   = '0;
    dq_d  = '0;
    ctl_d = CTL_PARK;
    if (state_d == FAULT) begin
      ctl_d = CTL_FAULT;
    end else if (state_d == BUSY) begin
      a_d   = sel_a;
      dq_d  = sel_dq;
      ctl_d = sel_ctl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      err_q   <= '0;
      a_q     <= '0;
      dq_q    <= '0;
      ctl_q   <= CTL_PARK;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      a_q     <= a_d;
      dq_q    <= dq_d;
      ctl_q   <= ctl_d;
    end
  end

  assign eng_en    = (state_q == START) ? own_oh : 3'b000;
  assign gnt       = (state_q == START || state_q == BUSY) ? own_oh : 3'b000;
  assign eng_rst_n = (state_q == FAULT) ? ~own_oh : 3'b111;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign wp        = 1'b1;

  assign A     = a_q;
  assign dq_o  = dq_q;
  assign rst_f = ctl_q[5];
  assign adv   = ctl_q[4];
  assign we    = ctl_q[3];
  assign ce    = ctl_q[2];
  assign oe    = ctl_q[1];
  assign dqe   = ctl_q[0];

endmodule
